// File: rtl/jump_redirect_unit.sv
// ID-stage J/JAL/JR/JALR resolver with a circular return-address stack; every output is registered (1-cycle latency).
// There is no backpressure: a stall or flush suppresses only the current cycle's action, and pulses last exactly one cycle.
module jump_redirect_unit #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4,
  parameter bit WORD_ADDR = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [31:0]                  id_instr,
  input  logic [ADDR_W-1:0]            id_pc,
  input  logic [ADDR_W-1:0]            id_rs_data,
  output logic                         redirect_valid,
  output logic [ADDR_W-1:0]            redirect_pc,
  output logic                         link_valid,
  output logic [4:0]                   link_reg,
  output logic [ADDR_W-1:0]            link_addr,
  output logic                         ras_mispredict,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic [15:0]                  mispredict_cnt
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_redirect_valid;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic              r_link_valid;
  logic [4:0]        r_link_reg;
  logic [ADDR_W-1:0] r_link_addr;
  logic              r_mispredict;
  logic [15:0]       r_mispredict_cnt;

  logic              w_act;
  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs;
  logic [4:0]        w_rd;
  logic              w_is_j;
  logic              w_is_jal;
  logic              w_is_jr;
  logic              w_is_jalr;
  logic              w_ret;
  logic [27:0]       w_low;
  logic [ADDR_W-1:0] w_jtarget;
  logic [ADDR_W-1:0] w_top;

  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_redir_vld;
  logic [ADDR_W-1:0] w_redir_pc;
  logic              w_link_vld;
  logic [4:0]        w_link_reg;
  logic [ADDR_W-1:0] w_link_addr;
  logic              w_mispred;

  assign w_act     = id_valid & ~stall & ~flush;
  assign w_opcode  = id_instr[31:26];
  assign w_funct   = id_instr[5:0];
  assign w_rs      = id_instr[25:21];
  assign w_rd      = id_instr[15:11];
  assign w_is_j    = (w_opcode == 6'b000010);
  assign w_is_jal  = (w_opcode == 6'b000011);
  assign w_is_jr   = (w_opcode == 6'b000000) && (w_funct == 6'b001000);
  assign w_is_jalr = (w_opcode == 6'b000000) && (w_funct == 6'b001001);
  assign w_ret     = (w_is_jr | w_is_jalr) && (w_rs == 5'd31);
  assign w_top     = r_ras[r_ptr - PTR_ONE];

  assign w_low = WORD_ADDR ? {2'b00, id_instr[25:0]} : {id_instr[25:0], 2'b00};

  // With a 28-bit PC there is no region field to splice in.
  generate
    if (ADDR_W > 28) begin : g_region
      assign w_jtarget = {id_pc[ADDR_W-1:28], w_low};
    end else begin : g_noregion
      assign w_jtarget = w_low;
    end
  endgenerate

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = r_ptr;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_count;
    w_redir_vld = 1'b0;
    w_redir_pc  = r_redirect_pc;
    w_link_vld  = 1'b0;
    w_link_reg  = r_link_reg;
    w_link_addr = r_link_addr;
    w_mispred   = 1'b0;
    if (w_act) begin
      if (w_is_j || w_is_jal) begin
        w_redir_vld = 1'b1;
        w_redir_pc  = w_jtarget;
      end
      if (w_is_jal) begin
        w_link_vld  = 1'b1;
        w_link_reg  = 5'd31;
        w_link_addr = id_pc;
        w_wr_en     = 1'b1;
        w_ptr_nxt   = r_ptr + PTR_ONE;
        w_cnt_nxt   = (r_count == DEPTH_C) ? r_count : r_count + CNT_ONE;
      end
      if (w_is_jr || w_is_jalr) begin
        w_redir_vld = 1'b1;
        w_redir_pc  = id_rs_data;
        if (w_ret && (r_count != '0)) begin
          if (w_top == id_rs_data) w_redir_pc = w_top;
          else                     w_mispred  = 1'b1;
          // JALR $31,$31: pop and push collapse into overwriting the top slot.
          if (w_is_jalr && (w_rd == 5'd31)) begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_ptr - PTR_ONE;
          end else begin
            w_ptr_nxt = r_ptr - PTR_ONE;
            w_cnt_nxt = r_count - CNT_ONE;
          end
        end else if (w_ret && w_is_jalr && (w_rd == 5'd31)) begin
          w_wr_en   = 1'b1;
          w_ptr_nxt = r_ptr + PTR_ONE;
          w_cnt_nxt = CNT_ONE;
        end
        if (w_is_jalr && (w_rd != 5'd0)) begin
          w_link_vld  = 1'b1;
          w_link_reg  = w_rd;
          w_link_addr = id_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
      r_ptr            <= '0;
      r_count          <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_link_valid     <= 1'b0;
      r_link_reg       <= '0;
      r_link_addr      <= '0;
      r_mispredict     <= 1'b0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_wr_en) r_ras[w_wr_idx] <= id_pc;
      r_ptr            <= w_ptr_nxt;
      r_count          <= w_cnt_nxt;
      r_redirect_valid <= w_redir_vld;
      r_redirect_pc    <= w_redir_pc;
      r_link_valid     <= w_link_vld;
      r_link_reg       <= w_link_reg;
      r_link_addr      <= w_link_addr;
      r_mispredict     <= w_mispred;
      if (w_mispred && (r_mispredict_cnt != 16'hFFFF))
        r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign link_valid     = r_link_valid;
  assign link_reg       = r_link_reg;
  assign link_addr      = r_link_addr;
  assign ras_mispredict = r_mispredict;
  assign ras_count      = r_count;
  assign ras_empty      = (r_count == '0);
  assign ras_full       = (r_count == DEPTH_C);
  assign mispredict_cnt = r_mispredict_cnt;
endmodule
